// File: rtl/axi_read_arbiter.sv
// Two-master AXI read arbiter: one outstanding burst, grant held from address to last beat.
// Optional round-robin tie-break under `AXI_ARB_RR_EN (default build: fixed priority, M0 wins).
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

module axi_read_arbiter (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [`AXI_ID_BITS-1:0]   ARID_M0,
    input  logic [`AXI_ADDR_BITS-1:0] ARADDR_M0,
    input  logic [`AXI_LEN_BITS-1:0]  ARLEN_M0,
    input  logic [`AXI_SIZE_BITS-1:0] ARSIZE_M0,
    input  logic [1:0]                ARBURST_M0,
    input  logic                      ARVALID_M0,
    output logic                      ARREADY_M0,
    input  logic [`AXI_ID_BITS-1:0]   ARID_M1,
    input  logic [`AXI_ADDR_BITS-1:0] ARADDR_M1,
    input  logic [`AXI_LEN_BITS-1:0]  ARLEN_M1,
    input  logic [`AXI_SIZE_BITS-1:0] ARSIZE_M1,
    input  logic [1:0]                ARBURST_M1,
    input  logic                      ARVALID_M1,
    output logic                      ARREADY_M1,
    output logic [`AXI_ID_BITS-1:0]   RID_M0,
    output logic [`AXI_DATA_BITS-1:0] RDATA_M0,
    output logic [1:0]                RRESP_M0,
    output logic                      RLAST_M0,
    output logic                      RVALID_M0,
    input  logic                      RREADY_M0,
    output logic [`AXI_ID_BITS-1:0]   RID_M1,
    output logic [`AXI_DATA_BITS-1:0] RDATA_M1,
    output logic [1:0]                RRESP_M1,
    output logic                      RLAST_M1,
    output logic                      RVALID_M1,
    input  logic                      RREADY_M1,
    output logic [`AXI_IDS_BITS-1:0]  ARID_S,
    output logic [`AXI_ADDR_BITS-1:0] ARADDR_S,
    output logic [`AXI_LEN_BITS-1:0]  ARLEN_S,
    output logic [`AXI_SIZE_BITS-1:0] ARSIZE_S,
    output logic [1:0]                ARBURST_S,
    output logic                      ARVALID_S,
    input  logic                      ARREADY_S,
    input  logic [`AXI_IDS_BITS-1:0]  RID_S,
    input  logic [`AXI_DATA_BITS-1:0] RDATA_S,
    input  logic [1:0]                RRESP_S,
    input  logic                      RLAST_S,
    input  logic                      RVALID_S,
    output logic                      RREADY_S
);

    localparam int unsigned GntW = `AXI_IDS_BITS - `AXI_ID_BITS;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

    state_e state_q, state_d;
    logic   grant_q, grant_d;
`ifdef AXI_ARB_RR_EN
    logic   last_grant_q, last_grant_d;
`endif
    logic   arvalid_gnt;
    logic   rready_gnt;

    // Routing ignores the upper RID bits: only one burst can be in flight.
    logic   unused_rid_hi;
    assign unused_rid_hi = ^RID_S[`AXI_IDS_BITS-1:`AXI_ID_BITS];

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
`ifdef AXI_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
`ifdef AXI_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
`ifdef AXI_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        arvalid_gnt  = grant_q ? ARVALID_M1 : ARVALID_M0;
        rready_gnt   = grant_q ? RREADY_M1 : RREADY_M0;
        ARREADY_M0   = 1'b0;
        ARREADY_M1   = 1'b0;
        ARID_S       = '0;
        ARADDR_S     = '0;
        ARLEN_S      = '0;
        ARSIZE_S     = '0;
        ARBURST_S    = '0;
        ARVALID_S    = 1'b0;
        RREADY_S     = 1'b0;
        RID_M0       = '0;
        RDATA_M0     = '0;
        RRESP_M0     = '0;
        RLAST_M0     = 1'b0;
        RVALID_M0    = 1'b0;
        RID_M1       = '0;
        RDATA_M1     = '0;
        RRESP_M1     = '0;
        RLAST_M1     = 1'b0;
        RVALID_M1    = 1'b0;

        case (state_q)
            IDLE: begin
                if (ARVALID_M0 || ARVALID_M1) begin
                    grant_d = !ARVALID_M0;
`ifdef AXI_ARB_RR_EN
                    if (ARVALID_M0 && ARVALID_M1) grant_d = !last_grant_q;
`endif
                    state_d = ADDR;
                end
            end
            ADDR: begin
                ARVALID_S  = arvalid_gnt;
                ARID_S     = {GntW'(grant_q), grant_q ? ARID_M1 : ARID_M0};
                ARADDR_S   = grant_q ? ARADDR_M1 : ARADDR_M0;
                ARLEN_S    = grant_q ? ARLEN_M1 : ARLEN_M0;
                ARSIZE_S   = grant_q ? ARSIZE_M1 : ARSIZE_M0;
                ARBURST_S  = grant_q ? ARBURST_M1 : ARBURST_M0;
                ARREADY_M0 = !grant_q && ARREADY_S;
                ARREADY_M1 = grant_q && ARREADY_S;
                if (arvalid_gnt && ARREADY_S) state_d = DATA;
            end
            DATA: begin
                RREADY_S = rready_gnt;
                if (grant_q) begin
                    RID_M1    = RID_S[`AXI_ID_BITS-1:0];
                    RDATA_M1  = RDATA_S;
                    RRESP_M1  = RRESP_S;
                    RLAST_M1  = RLAST_S;
                    RVALID_M1 = RVALID_S;
                end else begin
                    RID_M0    = RID_S[`AXI_ID_BITS-1:0];
                    RDATA_M0  = RDATA_S;
                    RRESP_M0  = RRESP_S;
                    RLAST_M0  = RLAST_S;
                    RVALID_M0 = RVALID_S;
                end
                if (RVALID_S && rready_gnt && RLAST_S) begin
                    state_d = IDLE;
`ifdef AXI_ARB_RR_EN
                    last_grant_d = grant_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed scoreboard bench for axi_read_arbiter; tie expectations follow `AXI_ARB_RR_EN.
module tb_axi_read_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  ARID_M0, ARID_M1;
    logic [31:0] ARADDR_M0, ARADDR_M1;
    logic [3:0]  ARLEN_M0, ARLEN_M1;
    logic [2:0]  ARSIZE_M0, ARSIZE_M1;
    logic [1:0]  ARBURST_M0, ARBURST_M1;
    logic        ARVALID_M0, ARVALID_M1, ARREADY_M0, ARREADY_M1;
    logic [3:0]  RID_M0, RID_M1;
    logic [31:0] RDATA_M0, RDATA_M1;
    logic [1:0]  RRESP_M0, RRESP_M1;
    logic        RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1;
    logic        RREADY_M0, RREADY_M1;
    logic [7:0]  ARID_S;
    logic [31:0] ARADDR_S;
    logic [3:0]  ARLEN_S;
    logic [2:0]  ARSIZE_S;
    logic [1:0]  ARBURST_S;
    logic        ARVALID_S, ARREADY_S;
    logic [7:0]  RID_S;
    logic [31:0] RDATA_S;
    logic [1:0]  RRESP_S;
    logic        RLAST_S, RVALID_S, RREADY_S;

    typedef struct {
        logic        m;
        logic [31:0] data;
        logic [3:0]  rid;
        logic        last;
    } beat_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    logic  g_exp;
    logic [31:0] held;

    axi_read_arbiter dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0),
        .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
        .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1), .ARSIZE_M1(ARSIZE_M1),
        .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
        .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
        .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
        .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
        .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
        .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ar(input logic m, input logic v, input logic [3:0] id,
                          input logic [31:0] addr, input logic [3:0] len);
        if (m) begin
            ARVALID_M1 = v; ARID_M1 = id; ARADDR_M1 = addr; ARLEN_M1 = len;
            ARSIZE_M1 = 3'd2; ARBURST_M1 = 2'b01;
        end else begin
            ARVALID_M0 = v; ARID_M0 = id; ARADDR_M0 = addr; ARLEN_M0 = len;
            ARSIZE_M0 = 3'd2; ARBURST_M0 = 2'b01;
        end
    endtask

    task automatic set_rready(input logic m, input logic v);
        if (m) RREADY_M1 = v; else RREADY_M0 = v;
    endtask

    // Pop the oldest expected beat and compare it with what the DUT presents now.
    task automatic check_beat(input string tag);
        beat_t e;
        n_checks++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL %s_sb observed=empty expected=beat", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_rvalid"}, 64'(e.m ? RVALID_M1 : RVALID_M0), 64'(1));
            chk({tag, "_rvalid_other"}, 64'(e.m ? RVALID_M0 : RVALID_M1), 64'(0));
            chk({tag, "_rdata"}, 64'(e.m ? RDATA_M1 : RDATA_M0), 64'(e.data));
            chk({tag, "_rlast"}, 64'(e.m ? RLAST_M1 : RLAST_M0), 64'(e.last));
            chk({tag, "_rid"}, 64'(e.m ? RID_M1 : RID_M0), 64'(e.rid));
        end
    endtask

    // Full burst from IDLE; abort_at >= 0 pulses reset while that beat is on the bus.
    task automatic do_burst(input string tag, input logic m, input logic [3:0] id,
                            input logic [31:0] addr, input logic [3:0] len,
                            input int stall, input logic [3:0] rid_hi, input int abort_at);
        beat_t e;
        set_ar(m, 1'b1, id, addr, len);
        tick();
        chk({tag, "_arvalid_s"}, 64'(ARVALID_S), 64'(1));
        chk({tag, "_arid_s"}, 64'(ARID_S), 64'({3'b000, m, id}));
        chk({tag, "_araddr_s"}, 64'(ARADDR_S), 64'(addr));
        chk({tag, "_arlen_s"}, 64'(ARLEN_S), 64'(len));
        chk({tag, "_arready_gnt_low"}, 64'(m ? ARREADY_M1 : ARREADY_M0), 64'(0));
        ARREADY_S = 1'b1;
        #1;
        chk({tag, "_arready_gnt"}, 64'(m ? ARREADY_M1 : ARREADY_M0), 64'(1));
        chk({tag, "_arready_other"}, 64'(m ? ARREADY_M0 : ARREADY_M1), 64'(0));
        tick();
        set_ar(m, 1'b0, id, addr, len);
        ARREADY_S = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            if (b == abort_at) begin
                RVALID_S = 1'b1; RDATA_S = $urandom; RLAST_S = 1'b0; RID_S = {rid_hi, id};
                set_rready(m, 1'b1);
                #1;
                ARESET = 1'b1;
                #1;
                chk({tag, "_rst_rvalid0"}, 64'(RVALID_M0), 64'(0));
                chk({tag, "_rst_rvalid1"}, 64'(RVALID_M1), 64'(0));
                chk({tag, "_rst_rready_s"}, 64'(RREADY_S), 64'(0));
                tick();
                ARESET = 1'b0;
                #1;
                chk({tag, "_post_rst_arvalid_s"}, 64'(ARVALID_S), 64'(0));
                tick();
                chk({tag, "_post_rst_rvalid"}, 64'({RVALID_M1, RVALID_M0}), 64'(0));
                RVALID_S = 1'b0;
                set_rready(m, 1'b0);
                return;
            end
            e.m = m; e.data = $urandom; e.rid = id; e.last = (b == int'(len));
            sb.push_back(e);
            RVALID_S = 1'b1; RDATA_S = e.data; RLAST_S = e.last; RID_S = {rid_hi, id};
            RRESP_S = 2'b00;
            set_rready(m, !(b == 0 && stall > 0));
            for (int s = 0; s < stall && b == 0; s++) begin
                #1;
                chk({tag, "_stall_rready_s"}, 64'(RREADY_S), 64'(0));
                chk({tag, "_stall_rdata"}, 64'(m ? RDATA_M1 : RDATA_M0), 64'(e.data));
                tick();
            end
            set_rready(m, 1'b1);
            #1;
            chk({tag, "_rready_s"}, 64'(RREADY_S), 64'(1));
            check_beat(tag);
            tick();
        end
        RVALID_S = 1'b0; RLAST_S = 1'b0;
        RREADY_M0 = 1'b0; RREADY_M1 = 1'b0;
        #1;
        chk({tag, "_end_rvalid"}, 64'({RVALID_M1, RVALID_M0}), 64'(0));
        chk({tag, "_end_arvalid_s"}, 64'(ARVALID_S), 64'(0));
    endtask

    initial begin
        ARESET = 1'b1;
        set_ar(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        set_ar(1'b1, 1'b0, 4'h0, 32'h0, 4'h0);
        RREADY_M0 = 1'b0; RREADY_M1 = 1'b0; ARREADY_S = 1'b0;
        RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = 1'b0; RVALID_S = 1'b0;
        tick();
        ARVALID_M0 = 1'b1;
        tick();
        chk("reset_arvalid_s", 64'(ARVALID_S), 64'(0));
        chk("reset_arready", 64'({ARREADY_M1, ARREADY_M0}), 64'(0));
        chk("reset_rvalid", 64'({RVALID_M1, RVALID_M0}), 64'(0));
        chk("reset_rready_s", 64'(RREADY_S), 64'(0));
        chk("reset_arid_s", 64'(ARID_S), 64'(0));
        ARVALID_M0 = 1'b0;
        ARESET = 1'b0;
        tick();

        do_burst("single", 1'b0, 4'h2, 32'h0001_0000, 4'd3, 0, 4'h0, -1);
        do_burst("bp", 1'b1, 4'h7, 32'h0002_0040, 4'd1, 5, 4'h1, -1);
        do_burst("ridmis", 1'b0, 4'h9, 32'h0000_1000, 4'd1, 0, 4'hF, -1);
        do_burst("abort", 1'b0, 4'h4, 32'h0003_0000, 4'd7, 0, 4'h0, 2);
        do_burst("after_rst", 1'b1, 4'hA, 32'h0004_0000, 4'd2, 0, 4'h1, -1);

        // Both masters request back to back; grant order depends on tie-break mode.
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        set_ar(1'b0, 1'b1, 4'h3, 32'h0000_0100, 4'd0);
        set_ar(1'b1, 1'b1, 4'h5, 32'h0000_0200, 4'd0);
        ARREADY_S = 1'b1; RREADY_M0 = 1'b1; RREADY_M1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef AXI_ARB_RR_EN
            g_exp = k[0];
`else
            g_exp = 1'b0;
`endif
            tick();
            chk("tie_arvalid_s", 64'(ARVALID_S), 64'(1));
            chk("tie_arid_hi", 64'(ARID_S[7:4]), 64'({3'b000, g_exp}));
            chk("tie_arready_other", 64'(g_exp ? ARREADY_M0 : ARREADY_M1), 64'(0));
            tick();
            held = $urandom;
            sb.push_back('{m: g_exp, data: held, rid: (g_exp ? 4'h5 : 4'h3), last: 1'b1});
            RVALID_S = 1'b1; RLAST_S = 1'b1; RDATA_S = held;
            RID_S = {3'b000, g_exp, (g_exp ? 4'h5 : 4'h3)};
            #1;
            check_beat("tie");
            tick();
            RVALID_S = 1'b0; RLAST_S = 1'b0;
            #1;
            chk("tie_idle_arvalid_s", 64'(ARVALID_S), 64'(0));
            chk("tie_idle_arready", 64'({ARREADY_M1, ARREADY_M0}), 64'(0));
        end
        set_ar(1'b0, 1'b0, 4'h0, 32'h0, 4'd0);
        set_ar(1'b1, 1'b0, 4'h0, 32'h0, 4'd0);
        ARREADY_S = 1'b0;
        tick();
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
